// File: rtl/bus_arbiter.sv
// bus_arbiter: shares one bus between instruction fetch and data cycles, data first, big-endian lanes.
// Requesters hold *_req until their *_valid pulse; `define BUS_ALIGN_CHECK_EN rejects misaligned data cycles.
module bus_arbiter #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_address,
  output logic [31:0]           fetch_data,
  output logic                  fetch_valid,
  input  logic                  data_req,
  input  logic                  data_read,
  input  logic                  data_write,
  input  logic [1:0]            data_width,
  input  logic [ADDR_WIDTH-1:0] data_address,
  input  logic [31:0]           data_wdata,
  output logic [31:0]           data_rdata,
  output logic                  data_valid,
  output logic                  stall,
  output logic [ADDR_WIDTH-3:0] bus_address,
  output logic [31:0]           bus_data_out,
  input  logic [31:0]           bus_data_in,
  output logic [3:0]            bus_strobes,
  output logic                  bus_read,
  output logic                  bus_write,
  input  logic                  bus_ready,
  output logic                  bus_error
);
  typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;
  state_t state_q, state_d;
  logic err_q, err_d, bus_read_q, bus_read_d, bus_write_q, bus_write_d;
  logic fetch_valid_q, fetch_valid_d, data_valid_q, data_valid_d, bus_error_q, bus_error_d;
  logic [ADDR_WIDTH-3:0] bus_address_q, bus_address_d;
  logic [31:0] bus_data_out_q, bus_data_out_d, fetch_data_q, fetch_data_d, data_rdata_q, data_rdata_d;
  logic [3:0] bus_strobes_q, bus_strobes_d;
  logic dreq, freq, arb, done, bad, wr, unused_fetch_lo;
  logic [1:0] w_eff, lo;
  logic [3:0] strb;
  logic [31:0] wrep, rd;
  // the request being completed (or just answered) is not eligible for re-grant
  assign dreq = data_req && !data_valid_q && state_q != DATA;
  assign freq = fetch_req && !fetch_valid_q && state_q != FETCH;
  assign done = (state_q == FETCH && bus_ready) || (state_q == DATA && (bus_ready || err_q));
  assign arb = state_q == IDLE || done;
  assign wr = data_write && !data_read;
  assign w_eff = data_width == 2'b11 ? 2'b00 : data_width;
  assign lo = w_eff == 2'b10 ? data_address[1:0] : w_eff == 2'b01 ? {data_address[1], 1'b0} : 2'b00;
  assign strb = w_eff == 2'b10 ? 4'b1000 >> lo : w_eff == 2'b01 ? (lo[1] ? 4'b0011 : 4'b1100) : 4'b1111;
  assign wrep = w_eff == 2'b10 ? {4{data_wdata[7:0]}} : w_eff == 2'b01 ? {2{data_wdata[15:0]}} : data_wdata;
  assign unused_fetch_lo = ^fetch_address[1:0];
`ifdef BUS_ALIGN_CHECK_EN
  assign bad = data_width == 2'b11 || (data_width == 2'b01 && data_address[0]) ||
               (data_width == 2'b00 && data_address[1:0] != 2'b00);
`else
  assign bad = 1'b0;
`endif
  // rejected cycles carry no strobes, so they extract to zero
  assign rd = bus_strobes_q == 4'b1111 ? bus_data_in :
              bus_strobes_q == 4'b1100 ? {16'h0, bus_data_in[31:16]} :
              bus_strobes_q == 4'b0011 ? {16'h0, bus_data_in[15:0]} :
              bus_strobes_q == 4'b1000 ? {24'h0, bus_data_in[31:24]} :
              bus_strobes_q == 4'b0100 ? {24'h0, bus_data_in[23:16]} :
              bus_strobes_q == 4'b0010 ? {24'h0, bus_data_in[15:8]} :
              bus_strobes_q == 4'b0001 ? {24'h0, bus_data_in[7:0]} : 32'h0;
  assign stall = (data_req && !data_valid_q) || state_q == DATA;
  assign {fetch_data, fetch_valid, data_rdata, data_valid} = {fetch_data_q, fetch_valid_q, data_rdata_q, data_valid_q};
  assign {bus_address, bus_data_out, bus_strobes} = {bus_address_q, bus_data_out_q, bus_strobes_q};
  assign {bus_read, bus_write, bus_error} = {bus_read_q, bus_write_q, bus_error_q};
  always_ff @(posedge clock or posedge reset)
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  always_comb state_d = arb ? (dreq ? DATA : freq ? FETCH : IDLE) : state_q;
  always_comb begin
    err_d = err_q;
    bus_read_d = bus_read_q;
    bus_write_d = bus_write_q;
    bus_address_d = bus_address_q;
    bus_data_out_d = bus_data_out_q;
    bus_strobes_d = bus_strobes_q;
    fetch_data_d = fetch_data_q;
    data_rdata_d = data_rdata_q;
    fetch_valid_d = done && state_q == FETCH;
    data_valid_d = done && state_q == DATA;
    bus_error_d = done && state_q == DATA && err_q;
    if (done) begin
      bus_read_d = 1'b0;
      bus_write_d = 1'b0;
      bus_strobes_d = 4'b0000;
      fetch_data_d = state_q == FETCH ? bus_data_in : fetch_data_q;
      data_rdata_d = state_q == DATA ? rd : data_rdata_q;
    end
    if (arb && dreq) begin
      err_d = bad;
      bus_read_d = !bad && !wr;
      bus_write_d = !bad && wr;
      bus_address_d = data_address[ADDR_WIDTH-1:2];
      bus_data_out_d = wrep;
      bus_strobes_d = bad ? 4'b0000 : strb;
    end else if (arb && freq) begin
      err_d = 1'b0;
      bus_read_d = 1'b1;
      bus_write_d = 1'b0;
      bus_address_d = fetch_address[ADDR_WIDTH-1:2];
      bus_strobes_d = 4'b1111;
    end
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      err_q <= 1'b0;
      bus_read_q <= 1'b0;
      bus_write_q <= 1'b0;
      bus_address_q <= '0;
      bus_data_out_q <= '0;
      bus_strobes_q <= '0;
      fetch_data_q <= '0;
      data_rdata_q <= '0;
      fetch_valid_q <= 1'b0;
      data_valid_q <= 1'b0;
      bus_error_q <= 1'b0;
    end else begin
      err_q <= err_d;
      bus_read_q <= bus_read_d;
      bus_write_q <= bus_write_d;
      bus_address_q <= bus_address_d;
      bus_data_out_q <= bus_data_out_d;
      bus_strobes_q <= bus_strobes_d;
      fetch_data_q <= fetch_data_d;
      data_rdata_q <= data_rdata_d;
      fetch_valid_q <= fetch_valid_d;
      data_valid_q <= data_valid_d;
      bus_error_q <= bus_error_d;
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed and random bus cycles checked against a lane-arithmetic reference model.
module tb_bus_arbiter;
  logic clock = 1'b0, reset = 1'b1;
  logic fetch_req = 1'b0, data_req = 1'b0, data_read = 1'b0, data_write = 1'b0, bus_ready = 1'b0;
  logic [31:0] fetch_address = '0, data_address = '0, data_wdata = '0, bus_data_in = '0;
  logic [1:0] data_width = '0;
  logic [31:0] fetch_data, data_rdata, bus_data_out;
  logic [29:0] bus_address;
  logic [3:0] bus_strobes;
  logic fetch_valid, data_valid, stall, bus_read, bus_write, bus_error;
  int nchk = 0, nerr = 0;
  always #5 clock = ~clock;
  bus_arbiter #(.ADDR_WIDTH(32)) dut (
    .clock(clock), .reset(reset),
    .fetch_req(fetch_req), .fetch_address(fetch_address), .fetch_data(fetch_data), .fetch_valid(fetch_valid),
    .data_req(data_req), .data_read(data_read), .data_write(data_write), .data_width(data_width),
    .data_address(data_address), .data_wdata(data_wdata), .data_rdata(data_rdata), .data_valid(data_valid),
    .stall(stall), .bus_address(bus_address), .bus_data_out(bus_data_out), .bus_data_in(bus_data_in),
    .bus_strobes(bus_strobes), .bus_read(bus_read), .bus_write(bus_write), .bus_ready(bus_ready),
    .bus_error(bus_error)
  );
  function automatic int nbytes(input logic [1:0] w);
    return w == 2'b10 ? 1 : w == 2'b01 ? 2 : 4;
  endfunction
  function automatic int lane_off(input logic [1:0] w, input logic [31:0] a);
    return int'(a % 4) / nbytes(w) * nbytes(w);
  endfunction
  function automatic logic [31:0] m_strb(input logic [1:0] w, input logic [31:0] a);
    logic [31:0] s = '0;
    for (int k = 0; k < nbytes(w); k++) s[3 - (lane_off(w, a) + k)] = 1'b1;
    return s;
  endfunction
  function automatic logic [31:0] m_wrep(input logic [1:0] w, input logic [31:0] wd);
    logic [31:0] r = '0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % nbytes(w)) +: 8];
    return r;
  endfunction
  function automatic logic [31:0] m_rd(input logic [1:0] w, input logic [31:0] a, input logic [31:0] din);
    int n = nbytes(w);
    logic [31:0] r = din >> (8 * (4 - lane_off(w, a) - n));
    return n == 4 ? r : r & ((32'h1 << (8 * n)) - 32'h1);
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(negedge clock);
  endtask
  task automatic data_txn(input logic wr, input logic [1:0] w, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] din, input int lat);
    data_req = 1'b1; data_write = wr; data_read = !wr; data_width = w; data_address = a; data_wdata = wd;
    #1 chk("stall_req", 32'(stall), 32'd1);
    tick;
    chk("grant_rd", 32'(bus_read), 32'(!wr));
    chk("grant_wr", 32'(bus_write), 32'(wr));
    chk("addr", 32'(bus_address), a >> 2);
    chk("strb", 32'(bus_strobes), m_strb(w, a));
    if (wr) chk("wdata", bus_data_out, m_wrep(w, wd));
    data_address = $urandom; data_wdata = $urandom; data_width = 2'($urandom);
    repeat (lat) begin
      tick;
      chk("hold", 32'({bus_read, bus_write, stall}), 32'({!wr, wr, 1'b1}));
    end
    bus_data_in = din; bus_ready = 1'b1;
    tick;
    bus_ready = 1'b0; bus_data_in = $urandom;
    chk("dvalid", 32'(data_valid), 32'd1);
    chk("stall_done", 32'(stall), 32'd0);
    chk("bus_idle", 32'({bus_read, bus_write}), 32'd0);
    chk("berr", 32'(bus_error), 32'd0);
    if (!wr) chk("rdata", data_rdata, m_rd(w, a, din));
    data_req = 1'b0;
    tick;
    chk("dvalid_off", 32'(data_valid), 32'd0);
  endtask
  task automatic fetch_txn(input logic [31:0] a, input logic [31:0] din, input int lat);
    fetch_req = 1'b1; fetch_address = a;
    tick;
    chk("f_rd", 32'({bus_read, bus_write}), 32'b10);
    chk("f_addr", 32'(bus_address), a >> 2);
    chk("f_strb", 32'(bus_strobes), 32'hF);
    chk("f_stall", 32'(stall), 32'd0);
    fetch_address = $urandom;
    repeat (lat) begin
      tick;
      chk("f_hold", 32'(bus_read), 32'd1);
    end
    bus_data_in = din; bus_ready = 1'b1;
    tick;
    bus_ready = 1'b0;
    chk("fvalid", 32'(fetch_valid), 32'd1);
    chk("fdata", fetch_data, din);
    chk("f_done", 32'(bus_read), 32'd0);
    fetch_req = 1'b0;
    tick;
    chk("fvalid_off", 32'(fetch_valid), 32'd0);
  endtask
  initial begin
    logic [1:0] w;
    logic [31:0] a;
    repeat (2) tick;
    chk("rst_ctl", 32'({bus_read, bus_write, fetch_valid, data_valid, bus_error, stall}), 32'd0);
    chk("rst_strb", 32'(bus_strobes), 32'd0);
    chk("rst_addr", 32'(bus_address), 32'd0);
    chk("rst_data", bus_data_out | fetch_data | data_rdata, 32'd0);
    reset = 1'b0;
    tick;
    fetch_txn(32'h100, 32'h12345678, 1);
    data_txn(1'b1, 2'b10, 32'h3, 32'hAB, 32'h0, 2);
    data_txn(1'b0, 2'b01, 32'h2, 32'h0, 32'hDEADBEEF, 1);
    bus_ready = 1'b1;
    tick;
    bus_ready = 1'b0;
    chk("idle_ready", 32'({fetch_valid, data_valid, bus_read, bus_write}), 32'd0);
    fetch_req = 1'b1; fetch_address = 32'h400;
    data_req = 1'b1; data_read = 1'b1; data_write = 1'b0; data_width = 2'b00; data_address = 32'h200;
    tick;
    chk("pri_data", 32'({bus_read, stall}), 32'b11);
    chk("pri_addr", 32'(bus_address), 32'h80);
    bus_ready = 1'b1; bus_data_in = 32'hCAFEF00D;
    tick;
    chk("pri_dvalid", 32'({data_valid, stall}), 32'b10);
    chk("pri_rdata", data_rdata, 32'hCAFEF00D);
    chk("pri_fetch", 32'({bus_read, bus_address}), 32'({1'b1, 30'h100}));
    data_req = 1'b0; bus_data_in = 32'h11223344;
    tick;
    bus_ready = 1'b0;
    chk("pri_fvalid", 32'({fetch_valid, data_valid, bus_read}), 32'b100);
    chk("pri_fdata", fetch_data, 32'h11223344);
    fetch_req = 1'b0;
    tick;
`ifdef BUS_ALIGN_CHECK_EN
    data_req = 1'b1; data_read = 1'b1; data_write = 1'b0; data_width = 2'b00; data_address = 32'h202;
    tick;
    chk("al_nobus", 32'({bus_read, bus_write, bus_strobes}), 32'd0);
    tick;
    chk("al_pulse", 32'({bus_error, data_valid}), 32'b11);
    chk("al_rdata", data_rdata, 32'd0);
    data_req = 1'b0;
    tick;
    chk("al_off", 32'({bus_error, data_valid}), 32'd0);
`else
    data_txn(1'b0, 2'b00, 32'h202, 32'h0, 32'h89ABCDEF, 0);
    data_txn(1'b0, 2'b11, 32'h7, 32'h0, 32'h01020304, 1);
`endif
    data_req = 1'b1; data_read = 1'b1; data_write = 1'b0; data_width = 2'b00; data_address = 32'h40;
    tick;
    chk("rst_mid_pre", 32'(bus_read), 32'd1);
    #2 reset = 1'b1;
    #1 chk("rst_mid_rd", 32'({bus_read, bus_strobes}), 32'd0);
    data_req = 1'b0;
    tick;
    reset = 1'b0; bus_ready = 1'b1;
    tick;
    bus_ready = 1'b0;
    chk("rst_after", 32'({fetch_valid, data_valid, bus_read, bus_write, stall}), 32'd0);
    tick;
    chk("rst_after2", 32'({fetch_valid, data_valid, bus_read}), 32'd0);
    for (int i = 0; i < 24; i++) begin
      w = 2'($urandom);
      a = $urandom;
`ifdef BUS_ALIGN_CHECK_EN
      if (w == 2'b11) w = 2'b00;
      a = a & ~32'(nbytes(w) - 1);
`endif
      data_txn(1'($urandom), w, a, $urandom, $urandom, int'($urandom_range(0, 3)));
    end
    for (int i = 0; i < 8; i++) fetch_txn($urandom, $urandom, int'($urandom_range(0, 3)));
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
